// File: rtl/gcd_stream_core.sv
// gcd_stream_core: WIDTH-generic binary (Stein) GCD engine with valid/ready on input and output.
//
// Ports:
//   clk_i        clock, all state on rising edge
//   reset_i      asynchronous active-high reset
//   in_valid_i   operand pair valid
//   in_ready_o   core can accept an operand pair (IDLE only)
//   operand_a_i  operand A, unsigned
//   operand_b_i  operand B, unsigned
//   out_valid_o  result valid, held until consumed
//   out_ready_i  downstream accepts result
//   gcd_o        gcd(A,B); gcd(x,0)=x; gcd(0,0)=0
//   zero_flag_o  at least one operand of this result was zero
//   busy_o       high in RUN and DONE
//   step_count_o RUN cycles used for this result (only with GCD_STEP_COUNT_EN)
//
// Optional feature macro: GCD_STEP_COUNT_EN adds a saturating step counter and step_count_o.
module gcd_stream_core #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] gcd_o,
    output logic             zero_flag_o,
    output logic             busy_o
`ifdef GCD_STEP_COUNT_EN
    ,
    output logic [CNT_W-1:0] step_count_o
`endif
);
    localparam int KW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
    logic [KW-1:0] k_q, k_d;
    logic zero_q, zero_d;
`ifdef GCD_STEP_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, scnt_q, scnt_d, cnt_inc;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign step_count_o = scnt_q;
`endif
    assign in_ready_o  = state_q == IDLE;
    assign out_valid_o = state_q == DONE;
    assign busy_o      = state_q != IDLE;
    assign gcd_o       = gcd_q;
    assign zero_flag_o = zero_q;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        gcd_d   = gcd_q;
        zero_d  = zero_q;
`ifdef GCD_STEP_COUNT_EN
        cnt_d   = cnt_q;
        scnt_d  = scnt_q;
`endif
        case (state_q)
            IDLE: if (in_valid_i) begin
                a_d     = operand_a_i;
                b_d     = operand_b_i;
                k_d     = '0;
                zero_d  = (operand_a_i == '0) || (operand_b_i == '0);
`ifdef GCD_STEP_COUNT_EN
                cnt_d   = '0;
`endif
                state_d = RUN;
            end
            RUN: begin
`ifdef GCD_STEP_COUNT_EN
                cnt_d = cnt_inc;
`endif
                if (a_q == '0 || b_q == '0) begin
                    // k counts shared factors of two; the product never exceeds the original operands
                    gcd_d   = (a_q | b_q) << k_q;
`ifdef GCD_STEP_COUNT_EN
                    scnt_d  = cnt_inc;
`endif
                    state_d = DONE;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + KW'(1);
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q >= b_q) begin
                    // difference of two odd values is even, so the shift is exact
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
            end
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            gcd_q   <= '0;
            zero_q  <= 1'b0;
`ifdef GCD_STEP_COUNT_EN
            cnt_q   <= '0;
            scnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            gcd_q   <= gcd_d;
            zero_q  <= zero_d;
`ifdef GCD_STEP_COUNT_EN
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
`endif
        end
    end
endmodule

// File: doc/gcd_stream_core.md
Name: gcd_stream_core

Overview:
Parametrised next-generation GCD engine for the sobel/gcd accelerator fabric. Replaces the fixed-width, enable-pulse GCD with a WIDTH-generic binary (Stein) GCD behind valid/ready handshakes on both input and output, so it can sit directly behind the SPI register front-end or a stream FIFO. Output results are held until they are consumed, and an operand-zero flag is provided.

Parameters:
WIDTH, 16, operand and result width in bits (>= 2)
CNT_W, 8, width of the step counter (optional feature); saturates at all-ones

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  asynchronous active-high reset
in_valid_i  in  1  operand pair valid
in_ready_o  out  1  core can accept an operand pair
operand_a_i  in  WIDTH  operand A, unsigned
operand_b_i  in  WIDTH  operand B, unsigned
out_valid_o  out  1  result valid, held until consumed
out_ready_i  in  1  downstream accepts result
gcd_o  out  WIDTH  gcd(A,B); gcd(x,0)=x; gcd(0,0)=0
zero_flag_o  out  1  at least one operand of this result was zero; qualified by out_valid_o
busy_o  out  1  high in RUN and DONE
step_count_o  out  CNT_W  RUN cycles used for this result (only with GCD_STEP_COUNT_EN)

Behaviour:
- Reset (async assert, sync release is upstream's job): state=IDLE; in_ready_o=1; out_valid_o=0; gcd_o=0; zero_flag_o=0; busy_o=0; step_count_o=0; internal a,b,k cleared.
- FSM: IDLE -> RUN on in_valid_i&&in_ready_o; RUN -> DONE on termination; DONE -> IDLE on out_valid_o&&out_ready_i.
- in_ready_o = (state==IDLE). No acceptance in RUN/DONE; no bypass. Max throughput one result per (RUN cycles + 2).
- Accept cycle: a<=operand_a_i, b<=operand_b_i, k<=0, zero_flag<=(A==0)||(B==0), count<=0.
- RUN, one step per cycle, priority order:
  1. a==0 or b==0: gcd_o<=(a|b)<<k (truncated to WIDTH; cannot overflow by construction); -> DONE.
  2. a,b both even: a>>=1, b>>=1, k++.
  3. a even only: a>>=1. 4. b even only: b>>=1.
  5. both odd: if a>=b then a<=(a-b)>>1 else b<=(b-a)>>1.
  Every RUN cycle, including the terminating one, increments count (saturating at 2^CNT_W-1).
- k width = clog2(WIDTH)+1; k never exceeds WIDTH-1 for nonzero operands.
- DONE: out_valid_o=1; gcd_o, zero_flag_o, step_count_o stable while out_ready_i is low. out_ready_i is ignored when out_valid_o=0.
- Latency: accept at cycle T; first RUN step T+1; out_valid_o rises the cycle after the terminating step. Bound: RUN cycles <= 2*WIDTH+1.
- busy_o = state!=IDLE.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; the pending result is discarded and not presented.
- Input values are sampled only on the accept cycle; later changes to the inputs have no effect.

Optional Feature:
GCD_STEP_COUNT_EN: when defined, the step counter and the step_count_o port exist and step_count_o is updated together with gcd_o on entry to DONE. When undefined, the port and counter are absent and there is no other behavioural difference.

Test Plan:
- Reset, then A=12,B=18 accepted at cycle 0 with out_ready_i=1 -> out_valid_o at cycle 6, gcd_o=6, zero_flag_o=0, step_count_o=5; in_ready_o high again at cycle 7.
- A=0,B=5 -> out_valid_o at cycle 2, gcd_o=5, zero_flag_o=1, step_count_o=1; A=0,B=0 -> gcd_o=0, zero_flag_o=1.
- WIDTH=16, A=65535,B=65535 -> gcd_o=65535; A=65535,B=32768 -> gcd_o=1; both within 33 RUN cycles.
- Backpressure: A=48,B=36 with out_ready_i=0 for 10 cycles after out_valid_o -> gcd_o=12 held stable, in_ready_o=0 throughout; pulse out_ready_i -> IDLE next cycle.
- Reset: raise reset_i while in RUN (A=1000,B=250) -> out_valid_o stays 0, in_ready_o=1 on the cycle after reset deassertion; then A=7,B=21 -> gcd_o=7.
- Random: 1000 pairs with random in_valid_i/out_ready_i gaps, compared with a reference model -> every result matches, in order, with no drops or duplicates.
